// File: rtl/rx_frame_sched.sv
// Frame scheduler: buffers decoded frames in a small FIFO and hands them to the host over valid/ready.
// Optional duplicate-frame suppression is compiled in with FRAME_DEDUP_EN.
module rx_frame_sched #(
  parameter int DEPTH     = 4,
  parameter int AW        = 2,
  parameter int DEDUP_WIN = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [15:0]   in_uid,
  input  logic [7:0]    in_zid,
  input  logic [7:0]    in_cnt,
  input  logic [7:0]    in_type,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_uid,
  output logic [7:0]    out_zid,
  output logic [7:0]    out_cnt,
  output logic [7:0]    out_type,
  output logic [AW:0]   level,
  output logic [7:0]    drop_cnt
);

  typedef logic [39:0] entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    drop_q, drop_d;

  logic   empty, full, pop, dup, push, drop;
  entry_t in_entry, head;

  assign in_entry = {in_uid, in_zid, in_cnt, in_type};
  assign empty    = (level_q == '0);
  assign full     = (level_q == (AW+1)'(DEPTH));
  assign pop      = !empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = in_valid && !dup && (!full || pop);
  assign drop     = in_valid && !dup && full && !pop;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      drop_d   = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (drop && (drop_q != 8'hFF)) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

`ifdef FRAME_DEDUP_EN
  localparam int TW = (DEDUP_WIN > 1) ? $clog2(DEDUP_WIN) : 1;

  logic [15:0]   key_uid_q, key_uid_d;
  logic [7:0]    key_cnt_q, key_cnt_d;
  logic          key_vld_q, key_vld_d;
  logic [TW-1:0] timer_q, timer_d;

  // zid/type are deliberately outside the key: a retransmit may differ there.
  assign dup = key_vld_q && (in_uid == key_uid_q) && (in_cnt == key_cnt_q);

  always_comb begin
    key_uid_d = key_uid_q;
    key_cnt_d = key_cnt_q;
    key_vld_d = key_vld_q;
    timer_d   = timer_q;
    if (flush) begin
      key_vld_d = 1'b0;
      timer_d   = '0;
    end else if (push) begin
      key_uid_d = in_uid;
      key_cnt_d = in_cnt;
      key_vld_d = 1'b1;
      timer_d   = TW'(DEDUP_WIN - 1);
    end else if (timer_q != '0) begin
      timer_d = timer_q - 1'b1;
      if (timer_q == TW'(1)) begin
        key_vld_d = 1'b0;
      end
    end else begin
      key_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_uid_q <= '0;
      key_cnt_q <= '0;
      key_vld_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      key_uid_q <= key_uid_d;
      key_cnt_q <= key_cnt_d;
      key_vld_q <= key_vld_d;
      timer_q   <= timer_d;
    end
  end
`else
  // The window length has no effect when suppression is compiled out.
  logic unused_win;
  assign unused_win = ^DEDUP_WIN;
  assign dup        = 1'b0;
`endif

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = !empty;
  assign out_uid   = head[39:24];
  assign out_zid   = head[23:16];
  assign out_cnt   = head[15:8];
  assign out_type  = head[7:0];
  assign level     = level_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_rx_frame_sched.sv
// Self-checking bench for rx_frame_sched: directed scenarios plus randomized traffic
// compared against a queue-based reference model (dedup modelled when FRAME_DEDUP_EN is set).
module tb_rx_frame_sched;
  localparam int DEPTH     = 4;
  localparam int AW        = 2;
  localparam int DEDUP_WIN = 1000;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_uid;
  logic [7:0]  in_zid, in_cnt, in_type;
  logic        out_valid;
  logic [15:0] out_uid;
  logic [7:0]  out_zid, out_cnt, out_type;
  logic [AW:0] level;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  rx_frame_sched #(.DEPTH(DEPTH), .AW(AW), .DEDUP_WIN(DEDUP_WIN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_uid(in_uid), .in_zid(in_zid), .in_cnt(in_cnt), .in_type(in_type),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_uid(out_uid), .out_zid(out_zid), .out_cnt(out_cnt), .out_type(out_type),
    .level(level), .drop_cnt(drop_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: frames in arrival order, drop count, last accepted key and its time.
  logic [39:0] q[$];
  int          drop_m  = 0;
  bit          kv_m    = 0;
  logic [23:0] key_m   = '0;
  int          acc_cyc = 0;
  int          cyc     = 0;

  task automatic model_reset();
    q.delete();
    drop_m = 0;
    kv_m   = 0;
  endtask

  task automatic model_edge();
    bit pop_m, dup_m, full_m;
    if (flush) begin
      model_reset();
    end else begin
      dup_m = 0;
`ifdef FRAME_DEDUP_EN
      dup_m = in_valid && kv_m && ({in_uid, in_cnt} == key_m) && ((cyc - acc_cyc) < DEDUP_WIN);
`endif
      full_m = (q.size() == DEPTH);
      pop_m  = (q.size() != 0) && out_ready;
      if (pop_m) void'(q.pop_front());
      if (in_valid && !dup_m) begin
        if (!full_m || pop_m) begin
          q.push_back({in_uid, in_zid, in_cnt, in_type});
          kv_m    = 1;
          key_m   = {in_uid, in_cnt};
          acc_cyc = cyc;
        end else if (drop_m < 255) begin
          drop_m++;
        end
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, q.size() != 0);
    chk("level", level, q.size());
    chk("drop_cnt", drop_cnt, drop_m);
    if (q.size() != 0) chk("head", {out_uid, out_zid, out_cnt, out_type}, q[0]);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic tick(input bit v, input logic [15:0] uid, input logic [7:0] cnt, input bit rdy);
    in_valid  = v;
    in_uid    = uid;
    in_cnt    = cnt;
    in_zid    = 8'($urandom);
    in_type   = 8'($urandom);
    out_ready = rdy;
    step();
  endtask

  task automatic do_flush();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_uid   = 16'hFFFF;
    in_cnt   = 8'hEE;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_uid = '0; in_zid = '0; in_cnt = '0; in_type = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_data", {out_uid, out_zid, out_cnt, out_type}, 40'h0);
    rst = 1'b0;

    // 1: single frame, one-cycle latency, then pop
    tick(1, 16'hA5C3, 8'h01, 1);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_uid", out_uid, 16'hA5C3);
    chk("t1_level1", level, 1);
    tick(0, 16'h0, 8'h0, 1);
    chk("t1_level0", level, 0);

    // 2: overflow with host stalled, then in-order pops
    for (int i = 0; i < 6; i++) tick(1, 16'h2000, 8'(i), 0);
    chk("t2_level", level, 4);
    chk("t2_drop", drop_cnt, 2);
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", out_cnt, i);
      tick(0, 16'h0, 8'h0, 1);
    end

    // 3: push and pop together while full
    do_flush();
    for (int i = 0; i < 4; i++) tick(1, 16'h3000, 8'(10 + i), 0);
    tick(1, 16'h3001, 8'h77, 1);
    chk("t3_level", level, 4);
    chk("t3_drop", drop_cnt, 0);
    for (int i = 0; i < 3; i++) tick(0, 16'h0, 8'h0, 1);
    chk("t3_last", out_cnt, 8'h77);
    tick(0, 16'h0, 8'h0, 1);

    // 4: drop counter saturation, then flush
    do_flush();
    for (int i = 0; i < 304; i++) tick(1, 16'h4000 + 16'(i), 8'(i), 0);
    chk("t4_sat", drop_cnt, 8'hFF);
    do_flush();
    chk("t4_flush_level", level, 0);
    chk("t4_flush_drop", drop_cnt, 0);
    chk("t4_flush_valid", out_valid, 1'b0);

    // 5: same key at offsets 0, 500, 1100
    tick(1, 16'hBEEF, 8'h05, 0);
    repeat (499) tick(0, 16'h0, 8'h0, 0);
    tick(1, 16'hBEEF, 8'h05, 0);
    repeat (599) tick(0, 16'h0, 8'h0, 0);
    tick(1, 16'hBEEF, 8'h05, 0);
`ifdef FRAME_DEDUP_EN
    chk("t5_entries", level, 2);
`else
    chk("t5_entries", level, 3);
`endif

    // 6: asynchronous reset mid-stream
    do_flush();
    for (int i = 0; i < 3; i++) tick(1, 16'h6000, 8'(i), 0);
    chk("t6_pre", level, 3);
    #3 rst = 1'b1;
    #1;
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_level", level, 0);
    chk("t6_data", {out_uid, out_zid, out_cnt, out_type}, 40'h0);
    model_reset();
    #1 rst = 1'b0;

    // Randomized traffic: small key pool, alternating host stall/drain phases
    for (int i = 0; i < 3000; i++) begin
      int rdy_pct;
      rdy_pct = ((i / 300) % 2 == 1) ? 8 : 2;
      flush = ($urandom_range(0, 199) == 0);
      tick(1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) == 1) ? 16'h1234 : 16'h5678,
           8'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < rdy_pct));
      flush = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
